// File: rtl/odd_seq_pkg.sv
// Shared types and helpers for the odd-counter sequence monitor.
// The sequence steps by two on a 4-bit value, so 15 wraps back to 1.
package odd_seq_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SEQ_STEP = 4'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] next_odd(input logic [CNT_W-1:0] v);
        return v + SEQ_STEP;
    endfunction

endpackage

// File: rtl/odd_seq_monitor_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/odd_seq_monitor.sv
// Checks the odd counter's output stream: locks onto 1,3,...,15,1 and
// reports sequence breaks, wraps and the last in-sequence value.
module odd_seq_monitor
    import odd_seq_pkg::*;
#(
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  count_in,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0]  last_good
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);
    localparam logic [CNT_W-1:0] TOP_VAL  = 4'd15;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    prev_q, prev_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [CNT_W-1:0]    last_good_q, last_good_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;
    logic                err_inc_s;
    logic                wrap_inc_s;
    logic                match_s;
    logic                odd_s;
    logic [RUN_W-1:0]    run_inc_s;

    assign match_s   = (count_in == next_odd(prev_q));
    assign odd_s     = count_in[0];
    assign run_inc_s = run_q + RUN_ONE;

    // Sequence FSM: acquisition, lock tracking and break detection.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        last_good_d = last_good_q;
        err_pulse_d = 1'b0;
        err_inc_s   = 1'b0;
        wrap_inc_s  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (odd_s) begin
                        prev_d  = count_in;
                        run_d   = {RUN_W{1'b0}};
                        state_d = ACQUIRE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACQUIRE: begin
                    if (match_s) begin
                        prev_d      = count_in;
                        run_d       = run_inc_s;
                        last_good_d = count_in;
                        if (run_inc_s == RUN_LOCK) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = ACQUIRE;
                        end
                    end else if (odd_s) begin
                        prev_d = count_in;
                        run_d  = {RUN_W{1'b0}};
                    end else begin
                        run_d   = {RUN_W{1'b0}};
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        prev_d      = count_in;
                        last_good_d = count_in;
                        wrap_inc_s  = (prev_q == TOP_VAL);
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc_s   = 1'b1;
                        run_d       = {RUN_W{1'b0}};
                        if (odd_s) begin
                            prev_d  = count_in;
                            state_d = ACQUIRE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = {RUN_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Lock flag and wrap counter next values; clr beats a same-cycle wrap.
    always_comb begin
        locked_d = (state_d == LOCKED);
        wrap_d   = wrap_q;
        if (clr) begin
            wrap_d = {WRAP_W{1'b0}};
        end else if (wrap_inc_s) begin
            wrap_d = wrap_q + {{(WRAP_W-1){1'b0}}, 1'b1};
        end else begin
            wrap_d = wrap_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= {CNT_W{1'b0}};
            run_q       <= {RUN_W{1'b0}};
            last_good_q <= {CNT_W{1'b0}};
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            wrap_q      <= {WRAP_W{1'b0}};
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            last_good_q <= last_good_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            wrap_q      <= wrap_d;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc_s),
        .clr   (clr),
        .q     (err_cnt)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign wrap_cnt  = wrap_q;
    assign last_good = last_good_q;

endmodule
